// File: rtl/shift_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_pkg : shared constants for the EX-stage shifter arbiter         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package shift_pkg;

  localparam logic REQ_EX  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  localparam int SHAMT_W = 5;
  localparam int XLEN    = 32;

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

endpackage
`default_nettype wire

// File: rtl/barrelshift.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | barrelshift : combinational 32-bit left/right logical/arith shifter  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module barrelshift
  import shift_pkg::*;
(
  input  logic [XLEN-1:0]    i_din,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic               i_al,
  input  logic               i_lr,
  output logic [XLEN-1:0]    o_dout
);

  always_comb begin
    o_dout = i_din << i_shamt;
    if (i_lr == DIR_R) begin
      if (i_al) o_dout = $unsigned($signed(i_din) >>> i_shamt);
      else      o_dout = i_din >> i_shamt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_rsp_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_rsp_slot : one-entry result buffer with drain/refill and clear  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module shift_rsp_slot
  import shift_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [XLEN-1:0]  i_dout,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_drain,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_dout,
  output logic [TAG_W-1:0] o_tag
);

  localparam logic [0:0] c_EMPTY = 1'b0;
  localparam logic [0:0] c_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [XLEN-1:0]  r_dout;
  logic [TAG_W-1:0] r_tag;

  always_ff @(posedge clk) begin
    if (i_clr) r_state <= c_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // A load in the draining cycle keeps the slot FULL with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    if (i_load)                              w_state_nxt = c_FULL;
    else if ((r_state == c_FULL) && i_drain) w_state_nxt = c_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_dout <= '0;
      r_tag  <= '0;
    end else if (i_load) begin
      r_dout <= i_dout;
      r_tag  <= i_tag;
    end
  end

  always_comb begin
    o_valid = (r_state == c_FULL);
    o_dout  = r_dout;
    o_tag   = r_tag;
  end

endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_arbiter : round-robin sharing of one barrelshift by two ports  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int RR_INIT = 0,
  parameter int TAG_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [31:0]        req0_din,
  input  logic [4:0]         req0_shamt,
  input  logic               req0_al,
  input  logic               req0_lr,
  input  logic [TAG_W-1:0]   req0_tag,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [31:0]        req1_din,
  input  logic [4:0]         req1_shamt,
  input  logic               req1_al,
  input  logic               req1_lr,
  input  logic [TAG_W-1:0]   req1_tag,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [31:0]        rsp0_dout,
  output logic [TAG_W-1:0]   rsp0_tag,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [31:0]        rsp1_dout,
  output logic [TAG_W-1:0]   rsp1_tag,
  input  logic               flush0
);

  localparam logic c_LAST_RST = (RR_INIT == 0) ? REQ_MEM : REQ_EX;

  logic              r_last;
  logic              w_elig0, w_elig1;
  logic              w_grant0, w_grant1;
  logic [XLEN-1:0]   w_sh_din, w_sh_dout;
  logic [SHAMT_W-1:0] w_sh_shamt;
  logic              w_sh_al, w_sh_lr;

  // A full slot is still eligible when its consumer drains it this cycle.
  assign w_elig0 = req0_valid & (~rsp0_valid | rsp0_ready) & ~flush0;
  assign w_elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

  assign w_grant0 = ~rst & w_elig0 & (~w_elig1 | (r_last == REQ_MEM));
  assign w_grant1 = ~rst & w_elig1 & (~w_elig0 | (r_last == REQ_EX));

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  always_ff @(posedge clk) begin
    if (rst)           r_last <= c_LAST_RST;
    else if (w_grant0) r_last <= REQ_EX;
    else if (w_grant1) r_last <= REQ_MEM;
  end

  always_comb begin
    w_sh_din   = w_grant1 ? req1_din   : req0_din;
    w_sh_shamt = w_grant1 ? req1_shamt : req0_shamt;
    w_sh_al    = w_grant1 ? req1_al    : req0_al;
    w_sh_lr    = w_grant1 ? req1_lr    : req0_lr;
  end

  barrelshift u_shift (
    .i_din   (w_sh_din),
    .i_shamt (w_sh_shamt),
    .i_al    (w_sh_al),
    .i_lr    (w_sh_lr),
    .o_dout  (w_sh_dout)
  );

  shift_rsp_slot #(.TAG_W(TAG_W)) u_slot0 (
    .clk     (clk),
    .i_clr   (rst | flush0),
    .i_load  (w_grant0),
    .i_dout  (w_sh_dout),
    .i_tag   (req0_tag),
    .i_drain (rsp0_ready),
    .o_valid (rsp0_valid),
    .o_dout  (rsp0_dout),
    .o_tag   (rsp0_tag)
  );

  shift_rsp_slot #(.TAG_W(TAG_W)) u_slot1 (
    .clk     (clk),
    .i_clr   (rst),
    .i_load  (w_grant1),
    .i_dout  (w_sh_dout),
    .i_tag   (req1_tag),
    .i_drain (rsp1_ready),
    .o_valid (rsp1_valid),
    .o_dout  (rsp1_dout),
    .o_tag   (rsp1_tag)
  );

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_shift_arbiter : directed + random checks against a slot/RR model  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_shift_arbiter;

  localparam int TAG_W   = 5;
  localparam int RR_INIT = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             v[2], rr[2], al[2], lr[2];
  logic [31:0]      d[2];
  logic [4:0]       sh[2];
  logic [TAG_W-1:0] tg[2];
  logic             fl, rst_i;

  logic             req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0]      rsp0_dout, rsp1_dout;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;

  shift_arbiter #(.RR_INIT(RR_INIT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst_i),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_din(d[0]), .req0_shamt(sh[0]),
    .req0_al(al[0]), .req0_lr(lr[0]), .req0_tag(tg[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_din(d[1]), .req1_shamt(sh[1]),
    .req1_al(al[1]), .req1_lr(lr[1]), .req1_tag(tg[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_dout(rsp0_dout), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_dout(rsp1_dout), .rsp1_tag(rsp1_tag),
    .flush0(fl)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: one buffered result per requester plus last-winner index.
  bit               m_full[2];
  logic [31:0]      m_dout[2];
  logic [TAG_W-1:0] m_tag[2];
  int               m_last;
  bit               m_g[2];

  function automatic logic [31:0] ref_shift(logic [31:0] din, logic [4:0] s, logic a, logic r);
    longint unsigned p, w;
    p = 1;
    for (int i = 0; i < int'(s); i++) p = p * 2;
    if (!r) begin
      w = {32'h0, din} * p;
    end else begin
      w = {((a && din[31]) ? 32'hFFFF_FFFF : 32'h0), din};
      w = w / p;
    end
    return w[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic set_req(input int x, input logic val, input logic [31:0] din,
                         input logic [4:0] s, input logic a, input logic r,
                         input logic [TAG_W-1:0] t);
    v[x] = val; d[x] = din; sh[x] = s; al[x] = a; lr[x] = r; tg[x] = t;
  endtask

  // Entered at a negedge with inputs applied; checks, clocks, advances model.
  task automatic step();
    bit e0, e1;
    #1;
    e0 = v[0] && (!m_full[0] || rr[0]) && !fl;
    e1 = v[1] && (!m_full[1] || rr[1]);
    m_g[0] = 1'b0; m_g[1] = 1'b0;
    if (!rst_i) begin
      if (e0 && e1) begin
        if (m_last == 0) m_g[1] = 1'b1;
        else             m_g[0] = 1'b1;
      end else begin
        m_g[0] = e0; m_g[1] = e1;
      end
    end
    chk("req0_ready", 32'(req0_ready), 32'(m_g[0]));
    chk("req1_ready", 32'(req1_ready), 32'(m_g[1]));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(m_full[0]));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(m_full[1]));
    if (m_full[0]) begin
      chk("rsp0_dout", rsp0_dout, m_dout[0]);
      chk("rsp0_tag", 32'(rsp0_tag), 32'(m_tag[0]));
    end
    if (m_full[1]) begin
      chk("rsp1_dout", rsp1_dout, m_dout[1]);
      chk("rsp1_tag", 32'(rsp1_tag), 32'(m_tag[1]));
    end
    @(posedge clk);
    if (rst_i) begin
      for (int x = 0; x < 2; x++) begin
        m_full[x] = 1'b0; m_dout[x] = '0; m_tag[x] = '0;
      end
      m_last = 1 - RR_INIT;
    end else begin
      for (int x = 0; x < 2; x++) begin
        if (x == 0 && fl)             m_full[0] = 1'b0;
        else if (m_g[x]) begin
          m_full[x] = 1'b1;
          m_dout[x] = ref_shift(d[x], sh[x], al[x], lr[x]);
          m_tag[x]  = tg[x];
        end else if (m_full[x] && rr[x]) m_full[x] = 1'b0;
      end
      if (m_g[0])      m_last = 0;
      else if (m_g[1]) m_last = 1;
    end
    @(negedge clk);
  endtask

  logic [31:0] held;

  initial begin
    for (int x = 0; x < 2; x++) begin
      set_req(x, 1'b0, '0, '0, 1'b0, 1'b0, '0);
      rr[x] = 1'b0; m_full[x] = 1'b0; m_dout[x] = '0; m_tag[x] = '0;
    end
    m_last = 1 - RR_INIT;
    fl = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    step();
    rst_i = 1'b0;
    chk("reset_dout0", rsp0_dout, 32'h0);
    chk("reset_tag1", 32'(rsp1_tag), 32'h0);

    // Single request, arithmetic then logical right shift
    set_req(0, 1'b1, 32'h8000_0001, 5'd4, 1'b1, 1'b1, 5'd7);
    step();
    v[0] = 1'b0;
    chk("single_ar_dout", rsp0_dout, 32'hF800_0000);
    chk("single_ar_tag", 32'(rsp0_tag), 32'd7);
    rr[0] = 1'b1;
    set_req(0, 1'b1, 32'h8000_0001, 5'd4, 1'b0, 1'b1, 5'd7);
    step();
    v[0] = 1'b0;
    chk("single_lr_dout", rsp0_dout, 32'h0800_0000);
    step();

    // Contention: grants alternate
    rr[0] = 1'b1; rr[1] = 1'b1;
    set_req(0, 1'b1, 32'h1234_5678, 5'd8, 1'b0, 1'b0, 5'd3);
    set_req(1, 1'b1, 32'h0000_0001, 5'd31, 1'b0, 1'b0, 5'd9);
    for (int i = 0; i < 4; i++) begin
      step();
      if (m_full[1]) chk("contend_rsp1", rsp1_dout, 32'h8000_0000);
    end

    // Backpressure on slot 0 (currently holds a result)
    rr[0] = 1'b0;
    step();
    held = rsp0_dout;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_dout0", rsp0_dout, held);
    end
    rr[0] = 1'b1;
    #1 chk("bp_release_ready0", 32'(req0_ready), 32'd1);
    step();

    // Drain plus refill with requester 1 idle
    v[1] = 1'b0; rr[0] = 1'b1;
    set_req(0, 1'b1, 32'h0000_00F0, 5'd4, 1'b0, 1'b1, 5'd12);
    #1 chk("refill_ready0", 32'(req0_ready), 32'd1);
    step();
    chk("refill_dout0", rsp0_dout, 32'h0000_000F);
    chk("refill_valid0", 32'(rsp0_valid), 32'd1);

    // Flush with slot 0 full and requester 1 contending
    rr[0] = 1'b0;
    set_req(0, 1'b1, 32'hDEAD_BEEF, 5'd1, 1'b0, 1'b0, 5'd1);
    set_req(1, 1'b1, 32'hCAFE_0000, 5'd16, 1'b1, 1'b1, 5'd2);
    rr[1] = 1'b1;
    fl = 1'b1;
    #1 chk("flush_ready0", 32'(req0_ready), 32'd0);
    chk("flush_ready1", 32'(req1_ready), 32'd1);
    step();
    fl = 1'b0; v[0] = 1'b0; v[1] = 1'b0;
    chk("flush_valid0", 32'(rsp0_valid), 32'd0);
    chk("flush_dout1", rsp1_dout, 32'hFFFF_CAFE);

    // Reset mid-operation with both slots full
    rr[0] = 1'b0; rr[1] = 1'b0;
    v[0] = 1'b1; v[1] = 1'b1;
    step(); step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst_valid0", 32'(rsp0_valid), 32'd0);
    chk("rst_valid1", 32'(rsp1_valid), 32'd0);
    chk("rst_dout0", rsp0_dout, 32'h0);
    chk("rst_dout1", rsp1_dout, 32'h0);
    chk("rst_tag0", 32'(rsp0_tag), 32'h0);
    #1 chk("rst_tie_winner0", 32'(req0_ready), (RR_INIT == 0) ? 32'd1 : 32'd0);
    step();

    // Random traffic; pending requests held until granted
    for (int n = 0; n < 400; n++) begin
      for (int x = 0; x < 2; x++) begin
        if (m_g[x] || !v[x] || rst_i || (x == 0 && fl))
          set_req(x, ($urandom_range(0, 3) != 0), $urandom, 5'($urandom),
                  1'($urandom), 1'($urandom), TAG_W'($urandom));
        rr[x] = ($urandom_range(0, 9) < 7);
      end
      fl    = ($urandom_range(0, 15) == 0);
      rst_i = ($urandom_range(0, 63) == 0);
      step();
    end
    rst_i = 1'b0; fl = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
# shift_arbiter

Two-port arbiter and sequencer for the shared 32-bit barrel shifter in the EX stage. It lets the ALU shift path (requester 0) and the load/store sub-word alignment path (requester 1) use a single `barrelshift` instance. Each request carries data, shift amount, arithmetic flag and direction, and gets a registered result one cycle later. The block uses valid/ready handshakes on both sides, round-robin tie-breaking, per-requester result buffering with backpressure, and a pipeline flush for requester 0.

## Interface
Parameters:
- RR_INIT, default 0: requester that wins the first tie after reset (0 or 1).
- TAG_W, default 5: width of the opaque tag echoed with each result (rd index for requester 0).

Ports (x = 0, 1):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- reqx_valid  in  1  request present.
- reqx_ready  out  1  request accepted this cycle (grant).
- reqx_din  in  32  operand.
- reqx_shamt  in  5  shift amount.
- reqx_al  in  1  1 = arithmetic (sign fill) on right shift.
- reqx_lr  in  1  0 = left, 1 = right.
- reqx_tag  in  TAG_W  echoed with the result.
- rspx_valid  out  1  result slot full.
- rspx_ready  in  1  consumer takes the result this cycle.
- rspx_dout  out  32  shifted result.
- rspx_tag  out  TAG_W  tag of that result.
- flush0  in  1  cancels requester 0 traffic (branch redirect).

## Operation
- **Response slots.** Each requester owns one result slot (EMPTY/FULL) holding dout and tag.
  - Drain: when the slot is FULL and rspx_ready=1, it goes EMPTY at the next edge unless it is refilled in the same cycle.
- **Eligibility.** Requester x is eligible when all of the following hold:
  - reqx_valid=1;
  - its slot is EMPTY, or FULL with rspx_ready=1 (same-cycle drain and refill);
  - for x=0 only, flush0=0.
- **Arbitration.**
  - At most one grant per cycle; the shifter is fed from the granted request.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the requester not granted last wins.
  - The last-granted pointer updates only on a grant. At reset it is set to 1−RR_INIT.
- **Handshake rules.**
  - reqx_ready = grant_x. It is combinational from the valid inputs, slot state and pointer, and is forced to 0 while rst=1.
  - A requester holds valid and its fields stable until ready.
- **Capture.** At the edge after a grant, the granted slot captures the `barrelshift` output and tag, and becomes FULL.
- **Shift arithmetic** (matches `barrelshift` exactly):
  - Left: zero fill.
  - Right: fill with din[31] if al=1, else 0.
  - shamt=0 passes din through.
- **flush0.**
  - In the flush cycle, req0 is not granted.
  - Slot 0 goes EMPTY at the next edge, regardless of rsp0_ready.
  - Requester 1 and the pointer are unaffected, except that requester 1 may win the cycle uncontested.
- **Output hold.** Slot contents stay stable while FULL and not drained; dout/tag never change under rspx_valid=1 without a handshake.
- **Reset** (synchronous, mid-operation included):
  - At the next edge, both slots go EMPTY, rspx_valid=0, rspx_dout=0, rspx_tag=0, and the pointer is reset.
  - In-flight grants are dropped.

## Timing
- Latency: request granted at edge N → rspx_valid=1 after edge N+1, with dout valid.
- Throughput: one result per cycle aggregate. A single requester with rsp ready held high gets one result per cycle, with no bubble on drain-plus-refill.
- Back-to-back contention: grants alternate 0,1,0,1…
- Combinational paths: req* → reqx_ready, rsp*_ready → reqx_ready. There is no combinational path from req to rsp.

## Structure
- Shared package/header `shift_pkg` holds:
  - requester index constants REQ_EX=0 and REQ_MEM=1;
  - SHAMT_W=5 and XLEN=32;
  - direction encodings DIR_L=0 and DIR_R=1.
- Reuse the existing `barrelshift` as the single datapath instance.
- Sub-module `shift_rsp_slot`, instantiated twice, contains:
  - the slot FULL flag, dout/tag registers and drain/refill logic;
  - a clear input driven by rst, and by flush0 for slot 0.

## Test plan
- Single request: req0 din=0x8000_0001, shamt=4, al=1, lr=1, tag=7 → next cycle rsp0_valid=1, dout=0xF800_0000, tag=7. Same with al=0 → 0x0800_0000.
- Contention: RR_INIT=0, both valid every cycle, both rsp ready=1, req1 din=0x1, shamt=31, lr=0 → grants 0,1,0,1. Each rsp1 dout=0x8000_0000.
- Backpressure: slot 0 FULL, rsp0_ready=0, req0 and req1 valid → req0_ready=0, req1 granted every cycle, rsp0_dout stable. Raising rsp0_ready → req0 granted the same cycle.
- Drain plus refill: slot 0 FULL, rsp0_ready=1, req0_valid=1, req1 idle → req0_ready=1, rsp0_valid stays 1 with the new dout next cycle.
- Flush: slot 0 FULL, req0_valid=1, flush0=1 for one cycle → req0_ready=0 that cycle, rsp0_valid=0 next cycle, a concurrent req1 is granted.
- Reset mid-operation: both slots FULL, rst=1 → reqx_ready=0 during rst, both rsp valid/dout/tag=0 after the edge. On the first tie after reset, requester RR_INIT wins.
